// File: rtl/axi_ic_pkg.sv
// Shared constants and width helpers for the interconnect control-path blocks.
package axi_ic_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefDepth = 4;

    // Pointer width for a FIFO of the given depth; kept at least 1 bit wide.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy counter width: one extra bit so the full count DEPTH is representable.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/pvs_fifo_ctrl.sv
// FIFO bookkeeping for pulse_valid_source: pointers, occupancy, push/pop
// decisions and the sticky overflow flag. Storage lives in the parent.
module pvs_fifo_ctrl
    import axi_ic_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned PtrW  = ptr_w(DEPTH),
    parameter int unsigned CntW  = cnt_w(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pulse_i,
    input  logic            ready_i,
    input  logic            clear_ovf_i,
    output logic            valid_o,
    output logic            push_o,
    output logic [PtrW-1:0] wr_ptr_o,
    output logic [PtrW-1:0] rd_ptr_o,
    output logic [CntW-1:0] pending_o,
    output logic            overflow_o
);

    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [PtrW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_d, rd_ptr_q;
    logic [CntW-1:0] count_d, count_q;
    logic            ovf_d, ovf_q;
    logic            valid_d, valid_q;
    logic            pop, push, drop, full;

    // Handshake decisions and next-state for pointers, count, valid and overflow.
    always_comb begin
        full = (count_q == FullCnt);
        pop  = valid_q & ready_i;
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        push = pulse_i & (~full | pop);
        drop = pulse_i & full & ~pop;

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        // Valid is registered from the next count so READY/Pulse_In never reach VALID combinationally.
        valid_d = (count_d != '0);

        // A drop on the same edge as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign valid_o    = valid_q;
    assign push_o     = push;
    assign wr_ptr_o   = wr_ptr_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign pending_o  = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/pulse_valid_source.sv
// Turns single-cycle payload pulses into a VALID/READY source, buffering
// bursts in a small FIFO while the sink stalls.
module pulse_valid_source
    import axi_ic_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     Pulse_In,
    input  logic [DATA_W-1:0]        Pulse_Data,
    output logic                     VALID,
    output logic [DATA_W-1:0]        DATA,
    input  logic                     READY,
    output logic [$clog2(DEPTH):0]   Pending,
    output logic                     Overflow,
    input  logic                     Clear_Ovf
);

    localparam int unsigned PtrW = ptr_w(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              push;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [DATA_W-1:0] mem_q [DEPTH];

    pvs_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PtrW  (PtrW),
        .CntW  (CntW)
    ) u_ctrl (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .pulse_i     (Pulse_In),
        .ready_i     (READY),
        .clear_ovf_i (Clear_Ovf),
        .valid_o     (VALID),
        .push_o      (push),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .pending_o   (Pending),
        .overflow_o  (Overflow)
    );

    // Payload storage; deliberately not reset, contents only observed while VALID.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr] <= Pulse_Data;
        end
    end

    // Head entry is driven straight from storage, which only changes on an edge.
    assign DATA = mem_q[rd_ptr];

endmodule

// File: tb/tb_pulse_valid_source.sv
// Self-checking bench for pulse_valid_source against a queue-based model.
module tb_pulse_valid_source;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic                   ACLK;
    logic                   ARESETN;
    logic                   Pulse_In;
    logic [DATA_W-1:0]      Pulse_Data;
    logic                   VALID;
    logic [DATA_W-1:0]      DATA;
    logic                   READY;
    logic [$clog2(DEPTH):0] Pending;
    logic                   Overflow;
    logic                   Clear_Ovf;

    pulse_valid_source #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .Pulse_In   (Pulse_In),
        .Pulse_Data (Pulse_Data),
        .VALID      (VALID),
        .DATA       (DATA),
        .READY      (READY),
        .Pending    (Pending),
        .Overflow   (Overflow),
        .Clear_Ovf  (Clear_Ovf)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: queue of accepted, unconsumed payloads plus sticky flag.
    logic [DATA_W-1:0] model_q [$];
    logic              model_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outputs();
        check("valid", 32'(VALID), 32'(model_q.size() != 0));
        check("pending", 32'(Pending), 32'(model_q.size()));
        check("overflow", 32'(Overflow), 32'(model_ovf));
        if (model_q.size() != 0) begin
            check("data", 32'(DATA), 32'(model_q[0]));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
    task automatic cycle(input logic pulse, input logic [DATA_W-1:0] data,
                         input logic ready, input logic clr);
        logic pop;
        logic full;
        Pulse_In   = pulse;
        Pulse_Data = data;
        READY      = ready;
        Clear_Ovf  = clr;
        @(posedge ACLK);
        pop  = (model_q.size() != 0) && ready;
        full = (model_q.size() == DEPTH);
        if (pop) begin
            void'(model_q.pop_front());
        end
        if (pulse && (!full || pop)) begin
            model_q.push_back(data);
        end
        if (pulse && full && !pop) begin
            model_ovf = 1'b1;
        end else if (clr) begin
            model_ovf = 1'b0;
        end
        @(negedge ACLK);
        check_outputs();
    endtask

    task automatic idle(input logic ready);
        cycle(1'b0, 8'h00, ready, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) begin
            idle(1'b1);
        end
    endtask

    initial begin
        ARESETN    = 1'b0;
        Pulse_In   = 1'b0;
        Pulse_Data = '0;
        READY      = 1'b0;
        Clear_Ovf  = 1'b0;
        model_ovf  = 1'b0;

        repeat (2) @(negedge ACLK);
        check("rst_valid", 32'(VALID), 32'd0);
        check("rst_pending", 32'(Pending), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        ARESETN = 1'b1;

        // Single pulse with READY high: one cycle of VALID, then empty again.
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        check("single_valid", 32'(VALID), 32'd1);
        check("single_data", 32'(DATA), 32'h5A);
        idle(1'b1);
        check("single_done", 32'(Pending), 32'd0);

        // Stall with three queued, then release.
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        idle(1'b0);
        check("stall_pending", 32'(Pending), 32'd3);
        check("stall_head", 32'(DATA), 32'h11);
        drain();

        // Overflow: six pulses into a four-deep FIFO.
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 4) check("ovf_before", 32'(Overflow), 32'd0);
        end
        check("ovf_pending", 32'(Pending), 32'(DEPTH));
        check("ovf_flag", 32'(Overflow), 32'd1);

        // Full with simultaneous pop and push: no overflow change, count holds.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(Overflow), 32'd0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check("full_pp_pending", 32'(Pending), 32'(DEPTH));
        check("full_pp_ovf", 32'(Overflow), 32'd0);
        drain();

        // Clear coincident with a drop: set wins; a later lone clear wins.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        check("set_wins", 32'(Overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("clear_alone", 32'(Overflow), 32'd0);
        drain();

        // Asynchronous reset with three pending and the flag set.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_pending", 32'(Pending), 32'd3);
        #2 ARESETN = 1'b0;
        #1;
        check("arst_valid", 32'(VALID), 32'd0);
        check("arst_pending", 32'(Pending), 32'd0);
        check("arst_overflow", 32'(Overflow), 32'd0);
        model_q.delete();
        model_ovf = 1'b0;
        #1 ARESETN = 1'b1;
        cycle(1'b1, 8'h9C, 1'b0, 1'b0);
        check("post_rst_data", 32'(DATA), 32'h9C);
        drain();

        // Randomised traffic in phases of varying sink pressure.
        for (int ph = 0; ph < 8; ph++) begin
            int unsigned ready_pct = $urandom_range(0, 100);
            int unsigned pulse_pct = $urandom_range(20, 100);
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom_range(0, 99) < pulse_pct),
                      8'($urandom),
                      ($urandom_range(0, 99) < ready_pct),
                      ($urandom_range(0, 15) == 0));
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_valid_source.md
# pulse_valid_source

Converts single-cycle event pulses, each carrying a payload word, into an AXI-style VALID/READY source that holds each word until the downstream accepts it. Events are buffered in a small FIFO so bursts of pulses are not lost while the sink stalls. It sits on the transmit side of interconnect control paths: a pulse-producing detector feeds it, and a VALID/READY consumer (arbiter, channel mux) drains it.

## Interface
- DATA_W, 8, payload width in bits
- DEPTH, 4, FIFO entries; power of two, minimum 2
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- Pulse_In  in  1  event strobe; every cycle it is high is one event
- Pulse_Data  in  DATA_W  payload sampled with Pulse_In
- VALID  out  1  source valid; registered
- DATA  out  DATA_W  payload at FIFO head; registered/storage-driven
- READY  in  1  sink ready
- Pending  out  $clog2(DEPTH)+1  number of stored, unaccepted events
- Overflow  out  1  sticky flag: an event was dropped
- Clear_Ovf  in  1  synchronous clear of Overflow

## Operation
- Reset: VALID=0, Pending=0, Overflow=0, read and write pointers 0. DATA undefined-but-stable (storage is not reset; bench must not check DATA while VALID=0).
- Push: edge with Pulse_In=1 and (Pending<DEPTH or pop this edge) writes Pulse_Data at wr_ptr, wr_ptr+1 mod DEPTH.
- Pop: edge with VALID=1 and READY=1; rd_ptr+1 mod DEPTH.
- Pending: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH, never underflows.
- VALID = (Pending!=0), derived from registered state; no combinational path from READY or Pulse_In to VALID or DATA.
- DATA = entry at rd_ptr.
- Full (Pending=DEPTH) with Pulse_In=1 and no pop: event dropped, FIFO unchanged, Overflow set at that edge.
- Full with Pulse_In=1 and pop same edge: push accepted, no overflow, Pending stays DEPTH.
- Empty with Pulse_In=1: no bypass; word appears after the edge.
- Overflow cleared by Clear_Ovf=1 at an edge; if an overflow drop occurs the same edge, set wins.
- Pointer wrap: pointers are $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Reset mid-operation: all pending events discarded immediately (asynchronous), VALID drops without handshake.

## Timing
- Latency: pulse sampled at edge k on empty FIFO -> VALID=1, DATA=payload during cycle k+1.
- AXI source rules: once VALID=1 it stays 1 and DATA stays stable until the accepting edge (VALID&READY).
- After an accepting edge, next word (if any) is presented in the following cycle; back-to-back acceptance sustains one word per cycle.
- READY may be asserted before VALID; no effect until VALID=1.
- Overflow and Pending update at the same edge as the event causing them.

## Structure
- Shared package axi_ic_pkg: default DATA_W and DEPTH constants, pointer/count width function or localparams.
- One sub-module natural: pvs_fifo_ctrl (pointers, Pending counter, push/pop/full/empty decisions, overflow flag); top holds storage array and output wiring.

## Test plan
- Reset then single pulse Data=0x5A at edge 3, READY=1 -> VALID=1 in cycle 4 only, DATA=0x5A, Pending returns 0 after edge 4.
- READY=0, pulses 0x11,0x22,0x33 on consecutive edges -> Pending=3, VALID held, DATA=0x11 stable; raise READY -> 0x11,0x22,0x33 on three consecutive accepts.
- READY=0, six pulses 0x01..0x06 with DEPTH=4 -> Pending=4, Overflow=1 from 5th pulse edge; drain yields 0x01..0x04 only.
- Full FIFO, READY=1 and pulse 0x77 same edge -> no overflow, Pending stays 4, 0x77 emerges last after draining.
- Overflow=1, Clear_Ovf=1 coincident with another dropped pulse -> Overflow stays 1; next Clear_Ovf alone -> 0.
- ARESETN low while Pending=3 and VALID=1 -> VALID=0, Pending=0, Overflow=0 immediately; post-reset pulse 0x9C delivered normally.
